// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Generic valid/ready pipeline stage with flush, back-pressure and
//            an optional 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic              reset_out
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL1 = 2'd1,
        ST_FULL2 = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_in_fire;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_pop_skid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic              r_reset_out;

    assign out_valid = (r_state != ST_EMPTY);

    // With the skid buffer, ready is a pure decode of the state flops so no
    // combinational path runs from out_ready back to in_ready.
    generate
        if (SKID != 0) begin : g_ready_reg
            assign in_ready = reset & (r_state != ST_FULL2);
        end else begin : g_ready_comb
            assign in_ready = reset & (~out_valid | out_ready);
        end
    endgenerate

    assign w_in_fire = in_valid & in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_pop_skid  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_FULL1;
                    w_load_main = 1'b1;
                end
            end
            ST_FULL1: begin
                if (w_in_fire && out_ready) begin
                    w_load_main = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = ST_FULL2;
                    w_load_skid = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL2: begin
                if (out_ready) begin
                    w_state_nxt = ST_FULL1;
                    w_pop_skid  = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_load_main = 1'b0;
            w_load_skid = 1'b0;
            w_pop_skid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
        end else if (w_load_main) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
        end else if (w_pop_skid) begin
            r_main_ctrl <= w_skid_ctrl;
            r_main_data <= w_skid_data;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else if (flush) begin
                    r_skid_ctrl <= '0;
                end else if (w_load_skid) begin
                    r_skid_ctrl <= in_ctrl;
                    r_skid_data <= in_data;
                end
            end

            assign w_skid_ctrl = r_skid_ctrl;
            assign w_skid_data = r_skid_data;
        end else begin : g_no_skid
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_reset_out <= 1'b0;
        end else begin
            r_reset_out <= 1'b1;
        end
    end

    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign occupancy = r_state;
    assign reset_out = r_reset_out;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Brief    : Bench for pipe_stage_skid; SKID=1 and SKID=0 instances share one
//            stimulus stream and are compared against a FIFO-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 128;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_ready;

    logic              u0_in_ready, u1_in_ready;
    logic              u0_out_valid, u1_out_valid;
    logic [CTRL_W-1:0] u0_out_ctrl, u1_out_ctrl;
    logic [DATA_W-1:0] u0_out_data, u1_out_data;
    logic [1:0]        u0_occ, u1_occ;
    logic              u0_reset_out, u1_reset_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u0_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(u0_out_valid), .out_ready(out_ready), .out_ctrl(u0_out_ctrl),
        .out_data(u0_out_data), .occupancy(u0_occ), .reset_out(u0_reset_out)
    );

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u1_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(u1_out_valid), .out_ready(out_ready), .out_ctrl(u1_out_ctrl),
        .out_data(u1_out_data), .occupancy(u1_occ), .reset_out(u1_reset_out)
    );

    task automatic chk(input string nm, input int k, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (skid=%0d): actual %0h required %0h", nm, k, act, exp);
        end
    endtask

    // Model: each instance is a FIFO of capacity 2 (SKID=1) or 1 (SKID=0)
    beat_t             mb    [2][2];
    int                mn    [2];
    logic [DATA_W-1:0] mlast [2];
    logic              mro   [2];
    logic              mvalid = 1'b0;

    function automatic logic m_ir(input int k);
        if (!reset) return 1'b0;
        if (k == 1) return (mn[1] < 2);
        return (mn[0] == 0) || out_ready;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (mvalid) begin
                    chk("in_ready", k, (k == 1) ? u1_in_ready : u0_in_ready, m_ir(k));
                    chk("out_valid", k, (k == 1) ? u1_out_valid : u0_out_valid, mn[k] > 0);
                    chk("out_ctrl", k, (k == 1) ? u1_out_ctrl : u0_out_ctrl,
                        (mn[k] > 0) ? mb[k][0].c : '0);
                    chk("out_data", k, (k == 1) ? u1_out_data : u0_out_data,
                        (mn[k] > 0) ? mb[k][0].d : mlast[k]);
                    chk("occupancy", k, (k == 1) ? u1_occ : u0_occ, mn[k]);
                    chk("reset_out", k, (k == 1) ? u1_reset_out : u0_reset_out, mro[k]);
                end
            end
            // Inputs are stable until the coming edge, so advance the model now
            for (int k = 0; k < 2; k++) begin
                automatic logic fire = in_valid && m_ir(k);
                if (!reset) begin
                    mn[k]    = 0;
                    mlast[k] = '0;
                    mro[k]   = 1'b0;
                end else if (flush) begin
                    if (mn[k] > 0) mlast[k] = mb[k][0].d;
                    mn[k]  = 0;
                    mro[k] = 1'b1;
                end else begin
                    if (mn[k] > 0 && out_ready) begin
                        mlast[k]  = mb[k][0].d;
                        mb[k][0]  = mb[k][1];
                        mn[k]     = mn[k] - 1;
                    end
                    if (fire) begin
                        mb[k][mn[k]] = {in_ctrl, in_data};
                        mn[k]        = mn[k] + 1;
                    end
                    mro[k] = 1'b1;
                end
            end
            if (!reset) mvalid = 1'b1;
        end
    end

    task automatic set_in(input logic r, input logic f, input logic iv, input logic orr,
                          input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        reset     = r;
        flush     = f;
        in_valid  = iv;
        out_ready = orr;
        in_ctrl   = c;
        in_data   = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 128'h5A5A);
        nxt();
        @(negedge clk);
        chk("rst in_ready", 1, u1_in_ready, 1'b0);
        chk("rst in_ready", 0, u0_in_ready, 1'b0);
        nxt();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("rst out_valid", 1, u1_out_valid, 1'b0);
        chk("rst out_ctrl", 1, u1_out_ctrl, '0);
        chk("rst occupancy", 1, u1_occ, 2'd0);
        chk("rst reset_out", 1, u1_reset_out, 1'b0);
        nxt();

        // Back-to-back streaming
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 1'b1, CTRL_W'(i + 1), DATA_W'(i));
            @(negedge clk);
            if (i == 0) begin
                chk("rel reset_out", 1, u1_reset_out, 1'b1);
                chk("rel in_ready", 1, u1_in_ready, 1'b1);
            end else begin
                chk("stream data", 1, u1_out_data, DATA_W'(i - 1));
                chk("stream ctrl", 1, u1_out_ctrl, CTRL_W'(i));
                chk("stream occ", 1, u1_occ, 2'd1);
            end
            nxt();
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
        @(negedge clk);
        chk("stream last", 1, u1_out_data, 128'd7);
        nxt();

        // Back-pressure
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h000A, 128'hA);
        nxt();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h000B, 128'hB);
        @(negedge clk);
        chk("bp full ready", 0, u0_in_ready, 1'b0);
        chk("bp skid ready", 1, u1_in_ready, 1'b1);
        nxt();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
        @(negedge clk);
        chk("bp occ2", 1, u1_occ, 2'd2);
        chk("bp in_ready", 1, u1_in_ready, 1'b0);
        chk("bp head A", 1, u1_out_data, 128'hA);
        nxt();
        @(negedge clk);
        chk("bp head B", 1, u1_out_data, 128'hB);
        chk("bp occ1", 1, u1_occ, 2'd1);
        chk("bp ready back", 1, u1_in_ready, 1'b1);
        nxt();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("bp drained", 1, u1_occ, 2'd0);
        chk("bp hold data", 1, u1_out_data, 128'hB);
        nxt();

        // Flush in FULL2 with a beat presented
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0021, 128'h21);
        nxt();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0022, 128'h22);
        nxt();
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 16'h00CC, 128'hCC);
        @(negedge clk);
        chk("fl pre occ", 1, u1_occ, 2'd2);
        nxt();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
        @(negedge clk);
        chk("fl out_valid", 1, u1_out_valid, 1'b0);
        chk("fl out_ctrl", 1, u1_out_ctrl, '0);
        chk("fl occ", 1, u1_occ, 2'd0);
        chk("fl in_ready", 1, u1_in_ready, 1'b1);
        chk("fl data kept", 1, u1_out_data, 128'h21);
        nxt();
        @(negedge clk);
        chk("fl no C", 1, u1_out_valid, 1'b0);
        nxt();

        // Single-register variant: ready follows out_ready in the same cycle
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0031, 128'h31);
        nxt();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0032, 128'h32);
        @(negedge clk);
        chk("s0 stall ready", 0, u0_in_ready, 1'b0);
        chk("s0 head D", 0, u0_out_data, 128'h31);
        nxt();
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 16'h0032, 128'h32);
        @(negedge clk);
        chk("s0 repl ready", 0, u0_in_ready, 1'b1);
        nxt();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("s0 head E", 0, u0_out_data, 128'h32);
        chk("s0 valid E", 0, u0_out_valid, 1'b1);
        nxt();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
        nxt();
        nxt();

        // Reset while FULL2 with downstream ready
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0041, 128'h41);
        nxt();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0042, 128'h42);
        nxt();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        @(negedge clk);
        chk("rf pre occ", 1, u1_occ, 2'd2);
        nxt();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("rf out_valid", 1, u1_out_valid, 1'b0);
        chk("rf occ", 1, u1_occ, 2'd0);
        chk("rf data zero", 1, u1_out_data, '0);
        chk("rf reset_out", 1, u1_reset_out, 1'b0);
        nxt();

        // Randomized traffic; back-pressure bias changes per phase
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 1000; i++) begin
                set_in($urandom_range(0, 63) != 0,
                       $urandom_range(0, 15) == 0,
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3) >= p,
                       CTRL_W'($urandom),
                       {$urandom, $urandom, $urandom, $urandom});
                nxt();
            end
        end

        set_in(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
        nxt();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- One generic stage with a valid/ready handshake, an optional 2-entry skid buffer, flush (bubble insertion) and back-pressure.
- Payload is split into a control field, zeroed on bubbles, and a data field, which holds its value.
- Used between any two pipeline stages so that stall and flush come from the hazard unit instead of ad-hoc gating.

Parameters:
- CTRL_W, 16, control payload width (RW, MW, MD, MB, FS, STRB... packed); bubble = all-zero control.
- DATA_W, 128, data payload width (PC, IMM, A, B, RS/RD indices... packed).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept; a beat transfers when in_valid & in_ready.
- in_ctrl  in  CTRL_W  upstream control payload.
- in_data  in  DATA_W  upstream data payload.
- flush  in  1  discard all held beats and any beat presented this cycle.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts; a beat transfers when out_valid & out_ready.
- out_ctrl  out  CTRL_W  head control; forced to 0 whenever out_valid = 0.
- out_data  out  DATA_W  head data; holds its last value when invalid.
- occupancy  out  2  number of held beats (0..2; max 1 when SKID = 0).
- reset_out  out  1  0 while in reset; 1 from the first clock edge with reset high.

Behaviour:
- All state updates on posedge clk; single clock domain.
- Priority each edge: reset, then flush, then handshake.
- Reset (reset = 0 at an edge):
  - state EMPTY; main and skid regs (ctrl, data) zeroed; reset_out = 0.
  - out_valid = 0, occupancy = 0.
  - in_ready forced to 0 combinationally while reset = 0.
  - Reset mid-operation drops all held beats with no partial transfer.
- Flush (reset = 1, flush = 1):
  - next state EMPTY; ctrl regs zeroed; data regs unchanged.
  - A beat presented with in_ready = 1 in that cycle counts as transferred upstream but is discarded.
  - out_ready is ignored that cycle.
  - In the following cycle, in_ready = 1.
- States, SKID = 1 (main = head, skid = second):
  - EMPTY: in_fire -> FULL1, main <= in.
  - FULL1:
    - in_fire & out_ready -> FULL1, main <= in.
    - in_fire & !out_ready -> FULL2, skid <= in.
    - !in_fire & out_ready -> EMPTY.
    - Otherwise hold.
  - FULL2: out_ready -> FULL1, main <= skid; otherwise hold.
  - in_ready = (state != FULL2), registered as a decode of the state flops with no path from out_ready.
- SKID = 0:
  - States EMPTY/FULL1 only; in_ready = !out_valid | out_ready (combinational).
  - FULL1 & in_fire & out_ready -> main <= in (zero-bubble throughput).
  - Skid regs are not instantiated.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid.
  - Sustained 1 beat/cycle when out_ready = 1.
  - Order is strictly FIFO; no beat is duplicated or lost except on flush or reset.
- Outputs:
  - out_ctrl = main_ctrl when out_valid, else 0.
  - out_data = main_data always.
  - occupancy = 0/1/2 for EMPTY/FULL1/FULL2.
- reset_out: registered; 0 on a reset edge, 1 on every edge with reset = 1.
- Width rules: payloads are passed bit-exact and never truncated or extended; CTRL_W and DATA_W must each be >= 1.

Test Plan:
- Reset: hold reset = 0 for 2 edges with in_valid = 1, in_ctrl = 16'hFFFF -> out_valid = 0, out_ctrl = 0, in_ready = 0, occupancy = 0, reset_out = 0. Release reset -> reset_out = 1 after 1 edge.
- Streaming (SKID = 1, out_ready = 1): 8 beats, data = 0..7, back-to-back -> each beat appears 1 cycle after its fire, in order, with no bubbles; occupancy stays 1.
- Back-pressure: fire beats A, B while out_ready = 0 -> occupancy 2, in_ready = 0, out_data = A. Raise out_ready for 2 cycles -> A then B delivered; in_ready = 1 after the first.
- Flush in FULL2 while in_valid = 1 (beat C) -> next cycle out_valid = 0, out_ctrl = 0, occupancy = 0, in_ready = 1; C never appears on the output.
- SKID = 0: out_ready = 0 with main full -> in_ready = 0 in the same cycle. out_ready = 1 with in_valid = 1 -> replacement beat accepted in the same cycle.
- Reset asserted in FULL2 with out_ready = 1 -> no beat delivered on that edge; EMPTY and zeroed registers afterwards.
